// File: rtl/switch_ingress_port.sv
// rtl/switch_ingress_port.sv - serial frame receiver with SFD/source check and frame FIFO
// Optional saturating drop counter built when INGRESS_DROP_CNT_EN is defined.
module switch_ingress_port #(
    parameter int         DEPTH       = 16,
    parameter int         ADDR_WIDTH  = 4,
    parameter logic [3:0] SFD_PATTERN = 4'b0101,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_bit,
    output logic [DEPTH-1:0]              out_frame,
    output logic [ADDR_WIDTH-1:0]         out_dst,
    output logic [ADDR_WIDTH-1:0]         out_src,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t             state_q, state_d;
    logic               rx_d1_q;
    logic [DEPTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [DEPTH-1:0]   mem_q [FIFO_DEPTH];

    logic [3:0]             rx_sfd;
    logic [ADDR_WIDTH-1:0]  rx_src;
    logic                   frame_ok;
    logic                   full;
    logic                   pop;
    logic                   push;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Falling edge on the idle-high line marks the start bit (SFD MSB).
                if (rx_d1_q && !rx_bit) begin
                    shreg_d = {shreg_q[DEPTH-2:0], rx_bit};
                    cnt_d   = CW'(DEPTH - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[DEPTH-2:0], rx_bit};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rx_d1_q <= 1'b1;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rx_d1_q <= rx_bit;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rx_sfd   = shreg_q[DEPTH-1 -: 4];
    assign rx_src   = shreg_q[DEPTH-5-ADDR_WIDTH -: ADDR_WIDTH];
    assign frame_ok = (rx_sfd == SFD_PATTERN) && (rx_src != {ADDR_WIDTH{1'b1}});

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign full       = (fifo_level == LW'(FIFO_DEPTH));
    assign out_valid  = (wr_ptr_q != rd_ptr_q);
    assign pop        = out_valid && out_ready;
    // A pop at the CHECK edge frees a slot, so a full FIFO can still accept.
    assign push       = (state_q == S_CHECK) && frame_ok && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PW-1:0]] <= shreg_q;
                wr_ptr_q                <= wr_ptr_q + LW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

    assign out_frame = mem_q[rd_ptr_q[PW-1:0]];
    assign out_dst   = out_frame[DEPTH-5 -: ADDR_WIDTH];
    assign out_src   = out_frame[DEPTH-5-ADDR_WIDTH -: ADDR_WIDTH];

`ifdef INGRESS_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = (state_q == S_CHECK) && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_switch_ingress_port.sv
// tb/tb_switch_ingress_port.sv - directed self-checking bench for switch_ingress_port
module tb_switch_ingress_port;

`ifdef INGRESS_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_bit = 1'b1;
    logic        out_ready = 1'b0;
    logic [15:0] out_frame;
    logic [3:0]  out_dst;
    logic [3:0]  out_src;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_drop = 0;

    switch_ingress_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_bit     (rx_bit),
        .out_frame  (out_frame),
        .out_dst    (out_dst),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_drop(input string tag);
        chk(tag, {24'd0, drop_cnt}, DROP_EN ? exp_drop : 0);
    endtask

    // Drives 16 bits MSB first on falling edges, then returns the line high.
    task automatic send(input logic [15:0] f);
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            rx_bit = f[i];
        end
        @(negedge clk);
        rx_bit = 1'b1;
    endtask

    initial begin
        logic [15:0] part;

        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_frame", out_frame, 0);
        chk("rst_dst", out_dst, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", out_valid, 0);

        // Single good frame, consumer always ready.
        out_ready = 1'b1;
        send(16'h5A3C);
        chk("t1_not_yet", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_frame", out_frame, 16'h5A3C);
        chk("t1_dst", out_dst, 4'hA);
        chk("t1_src", out_src, 4'h3);
        chk("t1_level", fifo_level, 1);
        @(negedge clk);
        chk("t1_valid_gone", out_valid, 0);
        chk("t1_level_gone", fifo_level, 0);

        // Bad SFD then good frame.
        send(16'h7A3C);
        @(negedge clk);
        chk("t2_bad_valid", out_valid, 0);
        exp_drop = 1;
        chk_drop("t2_drop");
        send(16'h5B2D);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_frame", out_frame, 16'h5B2D);
        chk("t2_dst", out_dst, 4'hB);
        chk("t2_src", out_src, 4'h2);
        @(negedge clk);
        chk("t2_valid_gone", out_valid, 0);

        // Broadcast source is rejected.
        send(16'h5AFC);
        @(negedge clk);
        chk("t3_valid", out_valid, 0);
        chk("t3_level", fifo_level, 0);
        exp_drop = 2;
        chk_drop("t3_drop");

        // Fill FIFO with consumer stalled; fifth frame dropped.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(16'h5000 + 16'(k));
            @(negedge clk);
        end
        chk("t4_level_full", fifo_level, 4);
        chk("t4_valid", out_valid, 1);
        chk("t4_head", out_frame, 16'h5001);
        send(16'h5005);
        @(negedge clk);
        chk("t4_level_after", fifo_level, 4);
        chk("t4_head_stable", out_frame, 16'h5001);
        exp_drop = 3;
        chk_drop("t4_drop");
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t4_order%0d", k), out_frame, 16'h5000 + 16'(k));
            chk($sformatf("t4_ovalid%0d", k), out_valid, 1);
        end
        @(negedge clk);
        chk("t4_drained_valid", out_valid, 0);
        chk("t4_drained_level", fifo_level, 0);

        // Full FIFO, but a pop coincides with CHECK: frame accepted.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(16'h5010 + 16'(k));
            @(negedge clk);
        end
        chk("t5_level_full", fifo_level, 4);
        send(16'h5015);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_level", fifo_level, 4);
        chk("t5_head", out_frame, 16'h5012);
        chk_drop("t5_no_drop");
        out_ready = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t5_order%0d", k), out_frame, 16'h5010 + 16'(k));
        end
        @(negedge clk);
        chk("t5_drained", out_valid, 0);

        // Reset in the middle of a frame with two frames queued.
        out_ready = 1'b0;
        send(16'h5021);
        @(negedge clk);
        send(16'h5022);
        @(negedge clk);
        chk("t6_level_pre", fifo_level, 2);
        part = 16'h5A3C;
        for (int i = 15; i >= 8; i--) begin
            @(negedge clk);
            rx_bit = part[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        rx_bit = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_frame", out_frame, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_drop = 0;
        chk_drop("t6_drop_cleared");
        chk("t6_idle_valid", out_valid, 0);
        out_ready = 1'b1;
        send(16'h5123);
        @(negedge clk);
        chk("t6_valid", out_valid, 1);
        chk("t6_frame", out_frame, 16'h5123);
        chk("t6_dst", out_dst, 4'h1);
        chk("t6_src", out_src, 4'h2);
        @(negedge clk);
        chk("t6_valid_gone", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
